// File: rtl/e203_tcm_ram_ctrl.sv
// e203_tcm_ram_ctrl: TCM SRAM with valid/ready command/response handshake and a
// 2-entry response FIFO, so response backpressure never drops read data.
// Optional per-byte even parity is enabled by defining E203_TCM_RAM_PARITY_EN.
module e203_tcm_ram_ctrl #(
  parameter int unsigned DP = 512,
  parameter int unsigned DW = 64,
  parameter int unsigned MW = DW / 8,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sd,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_read,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [MW-1:0] cmd_wmask,
  input  logic          cmd_perr_inj,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  logic          cmd_hs;
  logic          rsp_hs;
  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] mem_q [DP];
  logic [DW-1:0] rd_word;
  logic          rd_err;
  logic [DW-1:0] push_data;
  logic          push_err;

  // Response FIFO state
  logic [DW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_err_q;
  logic          head_q, tail_q;
  logic [1:0]    cnt_q, cnt_d;

  // Ready depends only on registered occupancy, sd and reset; never on rsp_ready.
  assign cmd_ready = rst_n & ~sd & (occ_q != 2'd2);
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign rsp_hs    = rsp_valid & rsp_ready;

  // Outstanding-command counter next state
  always_comb begin
    occ_d = occ_q;
    unique case ({cmd_hs, rsp_hs})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Outstanding-command counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Byte-masked RAM write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (cmd_hs && !cmd_read) begin
      for (int i = 0; i < int'(MW); i++) begin
        if (cmd_wmask[i]) mem_q[cmd_addr][8*i +: 8] <= cmd_wdata[8*i +: 8];
      end
    end
  end

  assign rd_word = mem_q[cmd_addr];

`ifdef E203_TCM_RAM_PARITY_EN
  logic [MW-1:0] par_q [DP];
  logic [MW-1:0] rd_par;

  // Parity write for masked-in bytes; inject flips the stored bit
  always_ff @(posedge clk) begin
    if (cmd_hs && !cmd_read) begin
      for (int i = 0; i < int'(MW); i++) begin
        if (cmd_wmask[i]) par_q[cmd_addr][i] <= (^cmd_wdata[8*i +: 8]) ^ cmd_perr_inj;
      end
    end
  end

  // Recompute parity over the whole word and flag any byte mismatch
  always_comb begin
    rd_par = '0;
    for (int i = 0; i < int'(MW); i++) begin
      rd_par[i] = ^rd_word[8*i +: 8];
    end
    rd_err = |(rd_par ^ par_q[cmd_addr]);
  end
`else
  logic unused_perr_inj;
  assign unused_perr_inj = cmd_perr_inj;
  assign rd_err          = 1'b0;
`endif

  // Write responses carry zero data and no error
  assign push_data = cmd_read ? rd_word : '0;
  assign push_err  = cmd_read & rd_err;

  // FIFO count next state; push and pop together leave it unchanged
  always_comb begin
    cnt_d = cnt_q;
    unique case ({cmd_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage and pointers; the RAM read lands directly in the tail entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_err_q     <= '0;
      head_q         <= 1'b0;
      tail_q         <= 1'b0;
      cnt_q          <= 2'd0;
    end else begin
      if (cmd_hs) begin
        fifo_data_q[tail_q] <= push_data;
        fifo_err_q[tail_q]  <= push_err;
        tail_q              <= ~tail_q;
      end
      if (rsp_hs) head_q <= ~head_q;
      cnt_q <= cnt_d;
    end
  end

  assign rsp_valid = (cnt_q != 2'd0);
  assign rsp_rdata = fifo_data_q[head_q];
  assign rsp_err   = fifo_err_q[head_q];

endmodule
